request_unit: RTL and testbench

- Sequences memory requests for the datapath from the decoded control outputs (dREN, dWEN, halt), i.e. the consumer side of the control-unit interface.
- Drives iREN/dREN/dWEN to the memory/cache port.
- Generates the PC-advance enable.
- Latches a sticky halt and keeps retire/stall performance counters.
- Sits between the control unit and the memory/cache interface inside the datapath.

---
 rtl/request_unit_pkg.sv | 4 +
 rtl/request_unit_if.sv | 10 +
 rtl/request_unit_sat_counter.sv | 12 +
 rtl/request_unit.sv | 105 ++++++++++
 tb/tb_request_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/request_unit_pkg.sv
// request_unit_pkg: shared request-sequencer state type
package request_unit_pkg;
  typedef enum logic [1:0] {FETCH, DMEM, HALTED} reqstate_t;
endpackage

// File: rtl/request_unit_if.sv
// request_unit_if: non-clock signals between the request unit and its neighbours
interface request_unit_if #(parameter int CNT_W = 32);
  logic cu_dREN, cu_dWEN, cu_halt, ihit, dhit;
  logic iREN, dREN, dWEN, pc_en, halt, err;
  logic [CNT_W-1:0] instr_cnt, stall_cnt;
  modport ru (input cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
              output iREN, dREN, dWEN, pc_en, halt, err, instr_cnt, stall_cnt);
  modport tb (output cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
              input iREN, dREN, dWEN, pc_en, halt, err, instr_cnt, stall_cnt);
endinterface

// File: rtl/request_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(parameter int W = 32) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge CLK) count_q <= RST ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/request_unit.sv
// request_unit: sequences fetch/data requests, PC-advance, sticky halt/error and perf counters
module request_unit
  import request_unit_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DMEM_TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int TW = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DMEM_TIMEOUT - 1);
  reqstate_t state_q, state_d;
  logic dren_q, dren_d, dwen_q, dwen_d, halt_q, halt_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic retire, stall;
  always_comb begin
    state_d = state_q;
    dren_d  = dren_q;
    dwen_d  = dwen_q;
    halt_d  = halt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    pc_en   = 1'b0;
    retire  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      FETCH:
        if (!ihit) stall = 1'b1;
        else if (cu_halt) begin
          state_d = HALTED;
          halt_d  = 1'b1;
          retire  = 1'b1;
        end else if (cu_dREN && cu_dWEN) begin
          state_d = HALTED;
          halt_d  = 1'b1;
          err_d   = 1'b1;
        end else if (cu_dREN || cu_dWEN) begin
          state_d = DMEM;
          dren_d  = cu_dREN;
          dwen_d  = cu_dWEN;
          tmo_d   = '0;
        end else begin
          pc_en  = 1'b1;
          retire = 1'b1;
        end
      DMEM:
        if (dhit) begin
          state_d = FETCH;
          pc_en   = 1'b1;
          retire  = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          tmo_d   = '0;
        end else begin
          stall = 1'b1;
          if (tmo_q == TMO_LAST) begin
            state_d = HALTED;
            halt_d  = 1'b1;
            err_d   = 1'b1;
            dren_d  = 1'b0;
            dwen_d  = 1'b0;
          end else tmo_d = tmo_q + 1'b1;
        end
      default: ;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end
  assign iREN = (state_q == FETCH);
  assign dREN = dren_q;
  assign dWEN = dwen_q;
  assign halt = halt_q;
  assign err  = err_q;
  sat_counter #(.W(CNT_W)) u_instr (.CLK(CLK), .RST(RST), .inc(retire), .count(instr_cnt));
  sat_counter #(.W(CNT_W)) u_stall (.CLK(CLK), .RST(RST), .inc(stall),  .count(stall_cnt));
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: scoreboard bench; each expected retirement is queued, monitor checks every pc_en
module tb_request_unit;
  typedef struct {
    int cnt;
    int dren;
    int dwen;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sbq[$];
  request_unit_if #(.CNT_W(4)) ifc ();
  request_unit #(.CNT_W(4), .DMEM_TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst),
    .cu_dREN(ifc.cu_dREN), .cu_dWEN(ifc.cu_dWEN), .cu_halt(ifc.cu_halt),
    .ihit(ifc.ihit), .dhit(ifc.dhit),
    .iREN(ifc.iREN), .dREN(ifc.dREN), .dWEN(ifc.dWEN), .pc_en(ifc.pc_en),
    .halt(ifc.halt), .err(ifc.err),
    .instr_cnt(ifc.instr_cnt), .stall_cnt(ifc.stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int c, input int r, input int w);
    exp_t e;
    e.cnt = c;
    e.dren = r;
    e.dwen = w;
    sbq.push_back(e);
  endtask
  task automatic drive(input logic r, input logic w, input logic h, input logic ih, input logic dh);
    ifc.cu_dREN = r;
    ifc.cu_dWEN = w;
    ifc.cu_halt = h;
    ifc.ihit = ih;
    ifc.dhit = dh;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic check_state(input string n, input int ir, input int dr, input int dw,
                             input int h, input int e, input int ic, input int sc);
    check({n, "_iREN"}, 32'(ifc.iREN), ir);
    check({n, "_dREN"}, 32'(ifc.dREN), dr);
    check({n, "_dWEN"}, 32'(ifc.dWEN), dw);
    check({n, "_halt"}, 32'(ifc.halt), h);
    check({n, "_err"}, 32'(ifc.err), e);
    check({n, "_instr"}, 32'(ifc.instr_cnt), ic);
    check({n, "_stall"}, 32'(ifc.stall_cnt), sc);
  endtask
  always @(negedge clk) begin
    if (!rst && ifc.pc_en) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pc_en: got 1 expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("retire_cnt", 32'(ifc.instr_cnt), e.cnt);
        check("retire_dREN", 32'(ifc.dREN), e.dren);
        check("retire_dWEN", 32'(ifc.dWEN), e.dwen);
      end
    end
  end
  initial begin
    drive(0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    check_state("reset", 1, 0, 0, 0, 0, 0, 0);
    // three back-to-back ALU instructions
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      push(i, 0, 0);
      step();
      check("alu_iREN", 32'(ifc.iREN), 1);
    end
    drive(0, 0, 0, 0, 0);
    check_state("alu", 1, 0, 0, 0, 0, 3, 0);
    // load with 4 stall cycles; an ihit while pending is ignored
    drive(1, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check_state("ld_pend", 0, 1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, i == 1, 0);
      step();
    end
    check_state("ld_wait", 0, 1, 0, 0, 0, 3, 4);
    drive(0, 0, 0, 0, 1);
    push(3, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check_state("ld_done", 1, 0, 0, 0, 0, 4, 4);
    // spurious dhit in FETCH, then a store with immediate dhit
    drive(0, 0, 0, 0, 1);
    step();
    check_state("spur_dhit", 1, 0, 0, 0, 0, 4, 5);
    drive(0, 1, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 1);
    check_state("st_pend", 0, 0, 1, 0, 0, 4, 5);
    push(4, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    check_state("st_done", 1, 0, 0, 0, 0, 5, 5);
    // HALT wins over dREN, retires without pc_en, then absorbs
    drive(1, 0, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check_state("halt", 0, 0, 0, 1, 0, 6, 5);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    check_state("halted", 0, 0, 0, 1, 0, 6, 5);
    do_reset();
    check_state("rst_halt", 1, 0, 0, 0, 0, 0, 0);
    // illegal simultaneous read and write
    drive(1, 1, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check_state("illegal", 0, 0, 0, 1, 1, 0, 0);
    do_reset();
    // data timeout after 8 pending cycles
    drive(1, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step();
    check_state("tmo_7", 0, 1, 0, 0, 0, 0, 7);
    step();
    check_state("tmo_8", 0, 0, 0, 1, 1, 0, 8);
    do_reset();
    // reset in the middle of a data access
    drive(0, 0, 0, 1, 0);
    push(0, 0, 0);
    step();
    drive(1, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    check_state("mid_pend", 0, 1, 0, 0, 0, 1, 1);
    do_reset();
    check_state("mid_rst", 1, 0, 0, 0, 0, 0, 0);
    // instruction counter saturates at 15
    for (int i = 0; i < 18; i++) begin
      drive(0, 0, 0, 1, 0);
      push(i > 15 ? 15 : i, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    check_state("sat", 1, 0, 0, 0, 0, 15, 0);
    step();
    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
